store_queue: RTL and testbench

Parametrised in-order store queue between the store address/data path and the data-memory write port. Each store is formatted into a word-aligned write with byte strobes, held until the ROB commits it, then drained to memory over a valid/ready handshake. Uncommitted entries are discarded on pipeline flush. Younger loads can read forwarded data from any entry whose bytes fully cover the load.

---
 rtl/store_queue_if.sv | 51 +++++
 rtl/store_queue.sv | 137 +++++++++++++
 tb/tb_store_queue.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_if.sv
// Store-queue port bundle: store request, ROB commit/flush, memory drain and
// load-forwarding signals. The slave modport is the queue, master the core side.
interface store_queue_if #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [2:0]            st_funct3;
  logic [ROB_WIDTH-1:0]  st_rob_id;

  logic                  commit_valid;
  logic [ROB_WIDTH-1:0]  commit_rob_id;
  logic                  flush;

  logic                  mem_wvalid;
  logic                  mem_wready;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;

  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [3:0]            ld_strb;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  fwd_stall;

  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, st_rob_id,
           commit_valid, commit_rob_id, flush, mem_wready, ld_addr, ld_strb,
    output st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
           fwd_hit, fwd_data, fwd_stall, count, empty, full
  );

  modport master (
    output st_valid, st_addr, st_data, st_funct3, st_rob_id,
           commit_valid, commit_rob_id, flush, mem_wready, ld_addr, ld_strb,
    input  st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
           fwd_hit, fwd_data, fwd_stall, count, empty, full
  );
endinterface

// File: rtl/store_queue.sv
// In-order store queue: formats stores into word writes with strobes, holds them
// until ROB commit, drains to memory and forwards data to younger loads.
module store_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5
) (
  input  logic         clk,
  input  logic         rst,
  store_queue_if.slave sq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  valid;
    logic                  cmt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            strb;
    logic [ROB_WIDTH-1:0]  rob;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic [PW-1:0] head, cmt, tail, cmt_c, idx, fwd_sel;
  logic [CW-1:0] count_q, ucnt, ucnt_c, count_nxt, ucnt_nxt;
  logic          empty_q, full_q;
  logic          fmt_ok, alloc, commit_ok, drain, fwd_found, fwd_cover;
  logic [1:0]    b;
  entry_t        new_ent, hd, ce;

  assign b  = sq.st_addr[1:0];
  assign hd = ent[head];
  assign ce = ent[cmt];

  // Lane placement of the store; unknown funct3 completes the handshake only.
  always_comb begin
    fmt_ok        = 1'b1;
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.addr  = {sq.st_addr[ADDR_WIDTH-1:2], 2'b00};
    new_ent.rob   = sq.st_rob_id;
    case (sq.st_funct3)
      3'b000: begin
        new_ent.data = {24'b0, sq.st_data[7:0]} << {b, 3'b000};
        new_ent.strb = 4'b0001 << b;
      end
      3'b001: begin
        new_ent.data = {16'b0, sq.st_data[15:0]} << {b[1], 4'b0000};
        new_ent.strb = 4'b0011 << {b[1], 1'b0};
      end
      3'b010: begin
        new_ent.data = sq.st_data;
        new_ent.strb = 4'b1111;
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  assign sq.st_ready = !full_q && !sq.flush;
  assign alloc       = sq.st_valid && sq.st_ready && fmt_ok;
  assign commit_ok   = sq.commit_valid && ce.valid && !ce.cmt && (ce.rob == sq.commit_rob_id);
  assign sq.mem_wvalid = hd.valid && hd.cmt;
  assign drain       = sq.mem_wvalid && sq.mem_wready;
  assign sq.mem_waddr  = sq.mem_wvalid ? hd.addr : '0;
  assign sq.mem_wdata  = sq.mem_wvalid ? hd.data : '0;
  assign sq.mem_wstrb  = sq.mem_wvalid ? hd.strb : '0;

  // Occupancy bookkeeping; ucnt counts uncommitted entries so a flush knows
  // how many to drop even when the pointers alias (full, all committed).
  always_comb begin
    cmt_c  = cmt + PW'(commit_ok);
    ucnt_c = ucnt - CW'(commit_ok);
    if (sq.flush) begin
      count_nxt = count_q - ucnt_c - CW'(drain);
      ucnt_nxt  = '0;
    end else begin
      count_nxt = count_q + CW'(alloc) - CW'(drain);
      ucnt_nxt  = ucnt_c + CW'(alloc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent     <= '0;
      head    <= '0;
      cmt     <= '0;
      tail    <= '0;
      count_q <= '0;
      ucnt    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (commit_ok) ent[cmt].cmt <= 1'b1;
      if (drain) begin
        ent[head].valid <= 1'b0;
        ent[head].cmt   <= 1'b0;
        head            <= head + PW'(1);
      end
      for (int i = 0; i < DEPTH; i++)
        if (sq.flush && ent[i].valid && !ent[i].cmt && !(commit_ok && cmt == PW'(i)))
          ent[i].valid <= 1'b0;
      if (alloc) ent[tail] <= new_ent;
      cmt     <= cmt_c;
      tail    <= sq.flush ? cmt_c : tail + PW'(alloc);
      count_q <= count_nxt;
      ucnt    <= ucnt_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Walk oldest to youngest so the last overlapping entry is the youngest one.
  always_comb begin
    fwd_found = 1'b0;
    fwd_sel   = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent[idx].valid && ent[idx].addr[ADDR_WIDTH-1:2] == sq.ld_addr[ADDR_WIDTH-1:2] &&
          |(ent[idx].strb & sq.ld_strb)) begin
        fwd_found = 1'b1;
        fwd_sel   = idx;
      end
    end
  end

  assign fwd_cover    = (ent[fwd_sel].strb & sq.ld_strb) == sq.ld_strb;
  assign sq.fwd_hit   = fwd_found && fwd_cover;
  assign sq.fwd_stall = fwd_found && !fwd_cover;
  assign sq.fwd_data  = sq.fwd_hit ? ent[fwd_sel].data : '0;

  assign sq.count = count_q;
  assign sq.empty = empty_q;
  assign sq.full  = full_q;
endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: vector table, directed corner sequences and a random
// phase, all cross-checked every cycle against a queue-based reference model.
module tb_store_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_queue_if #(.DEPTH(DEPTH)) sq ();
  store_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sq(sq));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [4:0]  rob;
    bit          cmt;
  } mentry_t;
  mentry_t mq[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fmt(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                              output bit ok, output logic [31:0] data, output logic [3:0] strb);
    int lane;
    ok = 1; data = '0; strb = '0;
    case (f)
      3'd0: begin lane = int'(a[1:0]); data[lane*8 +: 8] = d[7:0]; strb[lane] = 1'b1; end
      3'd1: begin lane = int'(a[1]); data[lane*16 +: 16] = d[15:0]; strb[lane*2 +: 2] = 2'b11; end
      3'd2: begin data = d; strb = 4'hF; end
      default: ok = 0;
    endcase
  endfunction

  function automatic int oldest_uncommitted();
    for (int i = 0; i < mq.size(); i++) if (!mq[i].cmt) return i;
    return -1;
  endfunction

  task automatic check_model();
    bit hit, stall, wv;
    logic [31:0] fdata, mask, act;
    hit = 0; stall = 0; fdata = '0; mask = '0;
    for (int l = 0; l < 4; l++) if (sq.ld_strb[l]) mask[l*8 +: 8] = 8'hFF;
    if (sq.ld_strb != 4'b0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].addr == {sq.ld_addr[31:2], 2'b00} && (mq[i].strb & sq.ld_strb) != 4'b0) begin
          if ((mq[i].strb & sq.ld_strb) == sq.ld_strb) begin hit = 1; fdata = mq[i].data; end
          else stall = 1;
          break;
        end
    chk("m_st_ready", sq.st_ready, (mq.size() < DEPTH) && !sq.flush);
    chk("m_count", sq.count, mq.size());
    chk("m_empty", sq.empty, mq.size() == 0);
    chk("m_full", sq.full, mq.size() == DEPTH);
    wv = (mq.size() > 0) && mq[0].cmt;
    chk("m_wvalid", sq.mem_wvalid, wv);
    if (wv) begin
      chk("m_waddr", sq.mem_waddr, mq[0].addr);
      chk("m_wdata", sq.mem_wdata, mq[0].data);
      chk("m_wstrb", sq.mem_wstrb, mq[0].strb);
    end
    chk("m_fwd_hit", sq.fwd_hit, hit);
    chk("m_fwd_stall", sq.fwd_stall, stall);
    if (hit) begin
      act = sq.fwd_data & mask;
      chk("m_fwd_data", act, fdata & mask);
    end
  endtask

  task automatic model_step();
    bit drn, acc, ok;
    int oi;
    mentry_t e;
    drn = (mq.size() > 0) && mq[0].cmt && sq.mem_wready;
    acc = sq.st_valid && (mq.size() < DEPTH) && !sq.flush;
    oi  = oldest_uncommitted();
    if (sq.commit_valid && oi >= 0 && mq[oi].rob == sq.commit_rob_id) mq[oi].cmt = 1;
    if (drn) void'(mq.pop_front());
    if (sq.flush) while (mq.size() > 0 && !mq[mq.size()-1].cmt) void'(mq.pop_back());
    if (acc) begin
      fmt(sq.st_addr, sq.st_data, sq.st_funct3, ok, e.data, e.strb);
      e.addr = {sq.st_addr[31:2], 2'b00};
      e.rob  = sq.st_rob_id;
      e.cmt  = 0;
      if (ok) mq.push_back(e);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic clear_inputs();
    sq.st_valid = 0; sq.st_addr = '0; sq.st_data = '0; sq.st_funct3 = '0; sq.st_rob_id = '0;
    sq.commit_valid = 0; sq.commit_rob_id = '0; sq.flush = 0; sq.mem_wready = 0;
    sq.ld_addr = '0; sq.ld_strb = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_count", sq.count, 0);
    chk("rst_empty", sq.empty, 1);
    chk("rst_full", sq.full, 0);
    chk("rst_st_ready", sq.st_ready, 1);
    chk("rst_wvalid", sq.mem_wvalid, 0);
    chk("rst_waddr", sq.mem_waddr, 0);
    chk("rst_wdata", sq.mem_wdata, 0);
    chk("rst_wstrb", sq.mem_wstrb, 0);
    chk("rst_fwd_hit", sq.fwd_hit, 0);
    chk("rst_fwd_stall", sq.fwd_stall, 0);
    chk("rst_fwd_data", sq.fwd_data, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    mq.delete();
    cycle();
    rst = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic [4:0] r);
    sq.st_valid = 1; sq.st_addr = a; sq.st_data = d; sq.st_funct3 = f; sq.st_rob_id = r;
    cycle();
    sq.st_valid = 0;
  endtask

  task automatic commit(input logic [4:0] r);
    sq.commit_valid = 1; sq.commit_rob_id = r;
    cycle();
    sq.commit_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int beats;
    bit got;
    logic [31:0] fd, a0, d0;
    logic [3:0] s0;
    logic [4:0] rob_ctr;
    int oi;

    vt[0] = '{32'h103, 32'hAABBCCDD, 3'd0, 32'h100, 32'hDD000000, 4'b1000};
    vt[1] = '{32'h200, 32'h12345678, 3'd0, 32'h200, 32'h00000078, 4'b0001};
    vt[2] = '{32'h201, 32'h00000055, 3'd0, 32'h200, 32'h00005500, 4'b0010};
    vt[3] = '{32'h302, 32'hCAFEBEEF, 3'd1, 32'h300, 32'hBEEF0000, 4'b1100};
    vt[4] = '{32'h301, 32'h1234ABCD, 3'd1, 32'h300, 32'h0000ABCD, 4'b0011};
    vt[5] = '{32'h407, 32'hDEADBEEF, 3'd2, 32'h404, 32'hDEADBEEF, 4'b1111};
    vt[6] = '{32'h007, 32'h00009876, 3'd1, 32'h004, 32'h98760000, 4'b1100};

    clear_inputs();
    rst = 1;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Table: each store goes alloc -> commit -> one drain beat.
    for (int v = 0; v < 7; v++) begin
      store(vt[v].addr, vt[v].data, vt[v].f3, 5'(v));
      commit(5'(v));
      sq.mem_wready = 1;
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
        if (sq.mem_wvalid) begin
          chk("vec_waddr", sq.mem_waddr, vt[v].exp_addr);
          chk("vec_wdata", sq.mem_wdata, vt[v].exp_data);
          chk("vec_wstrb", sq.mem_wstrb, vt[v].exp_strb);
          got = 1;
        end
        cycle();
      end
      if (!got) chk("vec_drain_timeout", 0, 1);
      sq.mem_wready = 0;
      chk("vec_empty_after", sq.empty, 1);
      chk("vec_single_beat", sq.mem_wvalid, 0);
    end

    // Fill, drain in order, wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(32'(i * 4), 32'h01010101 * 32'(i + 1), 3'd2, 5'(i));
    sq.st_valid = 1; sq.st_addr = 32'h20; sq.st_data = 32'h99; sq.st_funct3 = 3'd2; sq.st_rob_id = 5'd8;
    #1;
    chk("fill_full", sq.full, 1);
    chk("fill_st_ready", sq.st_ready, 0);
    chk("fill_tail_wrap", dut.tail, 0);
    cycle();
    sq.st_valid = 0;
    for (int i = 0; i < DEPTH; i++) commit(5'(i));
    sq.mem_wready = 1;
    beats = 0;
    for (int n = 0; n < 20 && beats < DEPTH; n++) begin
      if (sq.mem_wvalid) begin
        chk("fill_beat_addr", sq.mem_waddr, 32'(beats * 4));
        beats++;
      end
      cycle();
    end
    chk("fill_beats", beats, DEPTH);
    sq.mem_wready = 0;
    chk("fill_head_wrap", dut.head, 0);
    store(32'h20, 32'h99, 3'd2, 5'd8);
    chk("ninth_tail", dut.tail, 1);
    chk("ninth_count", sq.count, 1);
    sq.flush = 1; cycle(); sq.flush = 0;

    // Flush keeps only committed entries.
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(i * 4), 32'hF0 + 32'(i), 3'd2, 5'(10 + i));
    commit(5'd10);
    commit(5'd11);
    sq.flush = 1; cycle(); sq.flush = 0;
    chk("flush_count", sq.count, 2);
    chk("flush_tail", dut.tail, 2);
    commit(5'd12);
    chk("flush_stale_commit", sq.count, 2);
    sq.mem_wready = 1;
    beats = 0;
    for (int n = 0; n < 6; n++) begin
      if (sq.mem_wvalid) beats++;
      cycle();
    end
    sq.mem_wready = 0;
    chk("flush_beats", beats, 2);
    chk("flush_empty", sq.empty, 1);

    // Forwarding: youngest overlapping entry decides hit vs stall.
    store(32'h200, 32'h11223344, 3'd2, 5'd20);
    store(32'h201, 32'h00000055, 3'd0, 5'd21);
    sq.ld_addr = 32'h200; sq.ld_strb = 4'b0010; #1;
    fd = sq.fwd_data;
    chk("fwd_sb_hit", sq.fwd_hit, 1);
    chk("fwd_sb_data", fd[15:8], 8'h55);
    cycle();
    sq.ld_strb = 4'b1111; #1;
    chk("fwd_partial_stall", sq.fwd_stall, 1);
    chk("fwd_partial_hit", sq.fwd_hit, 0);
    cycle();
    sq.ld_addr = 32'h203; sq.ld_strb = 4'b0001; #1;
    fd = sq.fwd_data;
    chk("fwd_older_hit", sq.fwd_hit, 1);
    chk("fwd_older_data", fd[7:0], 8'h44);
    cycle();
    sq.ld_strb = 4'b0000; #1;
    chk("fwd_nostrb", {sq.fwd_hit, sq.fwd_stall}, 2'b00);
    cycle();
    sq.ld_addr = 32'h204; sq.ld_strb = 4'b1111; #1;
    chk("fwd_miss", {sq.fwd_hit, sq.fwd_stall}, 2'b00);
    cycle();
    sq.ld_strb = 4'b0000;
    sq.flush = 1; cycle(); sq.flush = 0;

    // Back-pressure hold, then async reset mid-drain.
    store(32'h300, 32'hCAFEF00D, 3'd2, 5'd1);
    commit(5'd1);
    #1;
    a0 = sq.mem_waddr; d0 = sq.mem_wdata; s0 = sq.mem_wstrb;
    chk("hold_wvalid0", sq.mem_wvalid, 1);
    chk("hold_waddr0", a0, 32'h300);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        rst = 1; #1;
        chk_reset_vals();
        mq.delete();
        cycle();
        rst = 0;
        break;
      end
      chk("hold_wvalid", sq.mem_wvalid, 1);
      chk("hold_waddr", sq.mem_waddr, a0);
      chk("hold_wdata", sq.mem_wdata, d0);
      chk("hold_wstrb", sq.mem_wstrb, s0);
      cycle();
    end

    // Random traffic against the model.
    rob_ctr = '0;
    for (int n = 0; n < 2000; n++) begin
      sq.st_valid  = 1'($urandom_range(0, 1));
      sq.st_addr   = 32'($urandom_range(0, 63));
      sq.st_data   = $urandom;
      sq.st_funct3 = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      sq.st_rob_id = rob_ctr;
      rob_ctr      = rob_ctr + 5'd1;
      oi = oldest_uncommitted();
      sq.commit_valid  = ($urandom_range(0, 2) != 0);
      sq.commit_rob_id = (oi >= 0 && $urandom_range(0, 99) < 85) ? mq[oi].rob : 5'($urandom_range(0, 31));
      sq.flush      = ($urandom_range(0, 19) == 0);
      sq.mem_wready = ($urandom_range(0, 2) != 0);
      sq.ld_addr    = 32'($urandom_range(0, 63));
      sq.ld_strb    = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
